// File: rtl/systolic_feeder_if.sv
// Operand/lane bundle between a systolic_feeder and its controller.
// Master drives start and the two operand matrices; the feeder drives the skewed lanes and status.
interface systolic_feeder_if #(
  parameter int DATA_W = 8
);
  logic                 start;
  logic [16*DATA_W-1:0] a_flat;
  logic [16*DATA_W-1:0] b_flat;
  logic [DATA_W-1:0]    west0, west4, west8, west12;
  logic [DATA_W-1:0]    north0, north1, north2, north3;
  logic                 array_clr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, a_flat, b_flat,
    input  west0, west4, west8, west12, north0, north1, north2, north3,
    input  array_clr, busy, done
  );

  modport slave (
    input  start, a_flat, b_flat,
    output west0, west4, west8, west12, north0, north1, north2, north3,
    output array_clr, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Captures two 4x4 operand matrices and streams them diagonally skewed into a 4x4
// systolic array: clear, 7 feed steps, zero drain, then a one-cycle done pulse.
module systolic_feeder #(
  parameter int DATA_W = 8,
  parameter int DRAIN  = 4
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);
  localparam int            CW     = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN - 1);
  localparam logic [2:0]    K_LAST = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [2:0]        k;
  logic [CW-1:0]     dcnt;
  logic [DATA_W-1:0] a_in    [16];
  logic [DATA_W-1:0] b_in    [16];
  logic [DATA_W-1:0] a_cap   [16];
  logic [DATA_W-1:0] b_cap   [16];
  logic [DATA_W-1:0] west_q  [4];
  logic [DATA_W-1:0] north_q [4];
  logic [DATA_W-1:0] west_n  [4];
  logic [DATA_W-1:0] north_n [4];
  logic              clr_q, busy_q, done_q;

  for (genvar e = 0; e < 16; e++) begin : g_unpack
    assign a_in[e] = bus.a_flat[e*DATA_W +: DATA_W];
    assign b_in[e] = bus.b_flat[e*DATA_W +: DATA_W];
  end

  // Lane values for the step the registers will hold next cycle (0 out of LOAD, k+1 in FEED).
  always_comb begin
    int unsigned s;
    s = (state == S_FEED) ? 32'(k + 3'd1) : 32'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      west_n[i]  = '0;
      north_n[i] = '0;
      if (s >= i && s - i <= 32'd3) begin
        west_n[i]  = a_cap[4'(3*i + s)];
        north_n[i] = b_cap[4'(4*(s - i) + i)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      dcnt    <= '0;
      a_cap   <= '{default: '0};
      b_cap   <= '{default: '0};
      west_q  <= '{default: '0};
      north_q <= '{default: '0};
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_cap  <= a_in;
            b_cap  <= b_in;
            state  <= S_LOAD;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          state   <= S_FEED;
          k       <= '0;
          clr_q   <= 1'b0;
          west_q  <= west_n;
          north_q <= north_n;
        end
        S_FEED: begin
          if (k == K_LAST) begin
            state   <= S_DRAIN;
            k       <= '0;
            dcnt    <= '0;
            west_q  <= '{default: '0};
            north_q <= '{default: '0};
          end else begin
            k       <= k + 3'd1;
            west_q  <= west_n;
            north_q <= north_n;
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.west0     = west_q[0];
  assign bus.west4     = west_q[1];
  assign bus.west8     = west_q[2];
  assign bus.west12    = west_q[3];
  assign bus.north0    = north_q[0];
  assign bus.north1    = north_q[1];
  assign bus.north2    = north_q[2];
  assign bus.north3    = north_q[3];
  assign bus.array_clr = clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
